// File: rtl/csa_resolve_adder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// csa_resolve_adder
//
// Carry-propagate stage that sits directly behind a carry-save adder. It takes
// the redundant pair (carry vector, weight 2; sum vector, weight 1) and resolves
// it to the binary value (carry << 1) + sum.
//
// The add is split into two pipeline stages at bit SPLIT:
//   stage 1 : bits [SPLIT-1:0] are added.
//             The carry out of that slice (c1) and the high operands are
//             registered.
//   stage 2 : bits [WIDTH-1:SPLIT] are added with c1 and the full result is
//             registered as the output.
// Both sides use a valid/ready handshake. A transfer happens on a rising edge
// where valid and ready are both high. The stages form a two-entry pipeline
// that sustains one result per cycle. Results leave in acceptance order.
//
// Parameters
//   WIDTH  operand/result width (CSA vector width), default 38
//   SPLIT  boundary between the stages; legal range 1..WIDTH-1, default 19
//
// Ports
//   clock      in   1      sole clock, rising edge
//   reset      in   1      asynchronous active-low reset
//   in_valid   in   1      in_carry/in_sum hold a valid pair
//   in_ready   out  1      stage 1 can accept the pair this cycle
//   in_carry   in   WIDTH  CSA carry vector, weight 2
//   in_sum     in   WIDTH  CSA sum vector, weight 1
//   out_valid  out  1      out_sum holds a resolved result
//   out_ready  in   1      consumer accepts out_sum this cycle
//   out_sum    out  WIDTH  ((in_carry << 1) + in_sum) mod 2^WIDTH
//   out_cout   out  2      bits [WIDTH+1:WIDTH] of the full sum
//                          (only when CSA_RESOLVE_COUT_EN is defined)
//
// Build option
//   CSA_RESOLVE_COUT_EN  When this macro is defined, the module adds the out_cout
//                        port and the overflow logic that drives it. When it is
//                        undefined, the upper bits are dropped and out_sum
//                        behaves the same.
// -----------------------------------------------------------------------------
module csa_resolve_adder #(
   parameter int WIDTH = 38,
   parameter int SPLIT = 19
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_carry,
   input  logic [WIDTH-1:0] in_sum,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum
`ifdef CSA_RESOLVE_COUT_EN
   ,
   output logic [1:0]       out_cout
`endif
);

   // Width of the upper slice resolved in stage 2.
   localparam int HW = WIDTH - SPLIT;

`ifdef CSA_RESOLVE_COUT_EN
   // The carry window keeps in_carry[WIDTH-1]. The upper add keeps two extra
   // bits, so the overflow into bits WIDTH and WIDTH+1 survives.
   localparam int CHW = HW + 1;
   localparam int HIW = HW + 2;
`else
   // Without the overflow output, in_carry[WIDTH-1] only lands above bit
   // WIDTH-1. The upper add can therefore be truncated to the result width.
   localparam int CHW = HW;
   localparam int HIW = HW;
`endif

   // --------------------------------------------------------------------------
   // Handshake
   // --------------------------------------------------------------------------
   logic s1_valid;
   logic s2_valid;
   logic s1_adv;
   logic in_fire;

   // Stage 1 moves forward when stage 2 is empty or is draining on this edge.
   // The result is that in_ready depends combinationally on out_ready only.
   assign s1_adv    = s1_valid && (!s2_valid || out_ready);
   assign in_ready  = !s1_valid || s1_adv;
   assign in_fire   = in_valid && in_ready;
   assign out_valid = s2_valid;

   // --------------------------------------------------------------------------
   // Stage 1: low slice
   // --------------------------------------------------------------------------
   // Carry vector shifted left by one and cut to the low slice. With SPLIT == 1
   // the low slice sees only the shifted-in zero.
   logic [SPLIT-1:0] lo_carry;

   if (SPLIT == 1) begin : g_lo_carry_zero
      assign lo_carry = '0;
   end else begin : g_lo_carry_shift
      assign lo_carry = {in_carry[SPLIT-2:0], 1'b0};
   end

   // The top bit of lo_full is the carry into the upper slice.
   logic [SPLIT:0] lo_full;
   assign lo_full = {1'b0, lo_carry} + {1'b0, in_sum[SPLIT-1:0]};

   logic [SPLIT-1:0] s1_lo;
   logic             s1_c1;
   logic [CHW-1:0]   s1_ch;
   logic [HW-1:0]    s1_sh;

   // NOTE: state is written with non-blocking assignments. Every flop then
   // samples the pre-edge values, and the two stages can shift in the same
   // cycle without racing each other.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_lo    <= '0;
         s1_c1    <= 1'b0;
         s1_ch    <= '0;
         s1_sh    <= '0;
      end else begin
         if (in_fire) begin
            s1_valid <= 1'b1;
            s1_lo    <= lo_full[SPLIT-1:0];
            s1_c1    <= lo_full[SPLIT];
            // The shifted carry window starts one bit lower, because
            // in_carry[k] carries weight 2^(k+1).
            s1_ch    <= in_carry[SPLIT-1 +: CHW];
            s1_sh    <= in_sum[WIDTH-1:SPLIT];
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end
      end
   end

`ifndef CSA_RESOLVE_COUT_EN
   // in_carry[WIDTH-1] only affects bits above the result when the overflow
   // output is not built. It is consumed here so that the unused bit is
   // explicit.
   logic unused_carry_msb;
   assign unused_carry_msb = in_carry[WIDTH-1];
`endif

   // --------------------------------------------------------------------------
   // Stage 2: high slice and output register
   // --------------------------------------------------------------------------
   logic [HIW-1:0] hi;
   assign hi = HIW'(s1_ch) + HIW'(s1_sh) + HIW'(s1_c1);

   logic [WIDTH-1:0] sum_q;
`ifdef CSA_RESOLVE_COUT_EN
   logic [1:0]       cout_q;
`endif

   // The output registers load only when stage 1 advances. While a result is
   // held under backpressure, out_sum/out_cout therefore stay unchanged.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s2_valid <= 1'b0;
         sum_q    <= '0;
`ifdef CSA_RESOLVE_COUT_EN
         cout_q   <= 2'b00;
`endif
      end else begin
         if (s1_adv) begin
            s2_valid <= 1'b1;
            sum_q    <= {hi[HW-1:0], s1_lo};
`ifdef CSA_RESOLVE_COUT_EN
            cout_q   <= hi[HW+1:HW];
`endif
         end else if (out_ready) begin
            s2_valid <= 1'b0;
         end
      end
   end

   assign out_sum  = sum_q;
`ifdef CSA_RESOLVE_COUT_EN
   assign out_cout = cout_q;
`endif

endmodule

// File: tb/tb_csa_resolve_adder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_csa_resolve_adder
//
// Directed bench for csa_resolve_adder with WIDTH=38 and SPLIT=19.
//
// A table of hand-computed vectors covers the resolve function and the
// latency. Hand-written sequences cover backpressure, a 100-pair stream at
// full throughput, and reset while the pipeline is full. Define
// CSA_RESOLVE_COUT_EN to also check out_cout.
// -----------------------------------------------------------------------------
module tb_csa_resolve_adder;

   localparam int WIDTH = 38;
   localparam int SPLIT = 19;

   logic             clock = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_carry;
   logic [WIDTH-1:0] in_sum;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
`ifdef CSA_RESOLVE_COUT_EN
   logic [1:0]       out_cout;
`endif

   csa_resolve_adder #(.WIDTH(WIDTH), .SPLIT(SPLIT)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_carry  (in_carry),
      .in_sum    (in_sum),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum)
`ifdef CSA_RESOLVE_COUT_EN
      ,
      .out_cout  (out_cout)
`endif
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge. Inputs are driven and outputs
   // are sampled there.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Reference result: the full (WIDTH+2)-bit value of (carry << 1) + sum.
   function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] s);
      return ({2'b00, c} << 1) + {2'b00, s};
   endfunction

   typedef struct {
      string            name;
      logic [WIDTH-1:0] carry;
      logic [WIDTH-1:0] sum;
      logic [WIDTH-1:0] exp_sum;
      logic [1:0]       exp_cout;
   } vec_t;

   vec_t vecs[8];

   // ---------------------------------------------------------------------------
   // Stream scoreboard: active only during the throughput run. It samples on
   // the falling edge, half a cycle away from the active edge.
   // ---------------------------------------------------------------------------
   bit               sb_en = 1'b0;
   logic [WIDTH+1:0] exp_q[$];
   logic [WIDTH+1:0] sb_exp;
   int               cyc = 0;
   int               n_results = 0;
   int               first_cyc = 0;
   int               last_cyc = 0;

   always @(negedge clock) begin
      if (sb_en) begin
         cyc++;
         if (in_valid && in_ready) exp_q.push_back(model(in_carry, in_sum));
         if (out_valid && out_ready) begin
            check("tp result expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               sb_exp = exp_q.pop_front();
               check($sformatf("tp result %0d sum", n_results), 64'(out_sum), 64'(sb_exp[WIDTH-1:0]));
`ifdef CSA_RESOLVE_COUT_EN
               check($sformatf("tp result %0d cout", n_results), 64'(out_cout), 64'(sb_exp[WIDTH+1:WIDTH]));
`endif
            end
            n_results++;
            if (n_results == 1) first_cyc = cyc;
            last_cyc = cyc;
         end
      end
   end

   // A hang becomes a failure with a visible message.
   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
      $fatal(1, "simulation time limit");
   end

   logic [63:0] rnd_c;
   logic [63:0] rnd_s;
   int          stalls;

   initial begin
      vecs[0] = '{"basic",      38'h0,            38'h3F_FFFF_FFFF, 38'h3F_FFFF_FFFF, 2'b00};
      vecs[1] = '{"split",      38'h1,            38'h7_FFFF,       38'h8_0001,       2'b00};
      vecs[2] = '{"wrap",       38'h3F_FFFF_FFFF, 38'h3F_FFFF_FFFF, 38'h3F_FFFF_FFFD, 2'b10};
      vecs[3] = '{"carry_msb",  38'h20_0000_0000, 38'h0,            38'h0,            2'b01};
      vecs[4] = '{"window_lsb", 38'h4_0000,       38'h0,            38'h8_0000,       2'b00};
      vecs[5] = '{"low_only",   38'h3_FFFF,       38'h1,            38'h7_FFFF,       2'b00};
      vecs[6] = '{"mixed",      38'h12_3456_789A, 38'h01_1111_1111, 38'h25_79BE_0245, 2'b00};
      vecs[7] = '{"carry_ones", 38'h3F_FFFF_FFFF, 38'h0,            38'h3F_FFFF_FFFE, 2'b01};

      reset     = 1'b0;
      in_valid  = 1'b0;
      in_carry  = '0;
      in_sum    = '0;
      out_ready = 1'b1;

      // ---- reset state ----
      step();
      step();
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset out_sum", 64'(out_sum), 64'd0);
      check("reset in_ready", 64'(in_ready), 64'd1);
`ifdef CSA_RESOLVE_COUT_EN
      check("reset out_cout", 64'(out_cout), 64'd0);
`endif
      reset = 1'b1;
      step();
      check("post-reset in_ready", 64'(in_ready), 64'd1);
      check("post-reset out_valid", 64'(out_valid), 64'd0);

      // ---- table vectors: one pair each, latency exactly 2 ----
      for (int i = 0; i < 8; i++) begin
         in_carry = vecs[i].carry;
         in_sum   = vecs[i].sum;
         in_valid = 1'b1;
         check($sformatf("vec%0d %s in_ready", i, vecs[i].name), 64'(in_ready), 64'd1);
         step();
         in_valid = 1'b0;
         check($sformatf("vec%0d %s valid after 1", i, vecs[i].name), 64'(out_valid), 64'd0);
         step();
         check($sformatf("vec%0d %s valid after 2", i, vecs[i].name), 64'(out_valid), 64'd1);
         check($sformatf("vec%0d %s sum", i, vecs[i].name), 64'(out_sum), 64'(vecs[i].exp_sum));
`ifdef CSA_RESOLVE_COUT_EN
         check($sformatf("vec%0d %s cout", i, vecs[i].name), 64'(out_cout), 64'(vecs[i].exp_cout));
`endif
         step();
         check($sformatf("vec%0d %s no duplicate", i, vecs[i].name), 64'(out_valid), 64'd0);
      end

      // ---- backpressure: (1,1) (2,0) (0,5), out_ready low for 5 cycles ----
      out_ready = 1'b0;
      in_carry  = 38'd1;
      in_sum    = 38'd1;
      in_valid  = 1'b1;
      check("bp accept A", 64'(in_ready), 64'd1);
      step();
      check("bp accept B", 64'(in_ready), 64'd1);
      in_carry = 38'd2;
      in_sum   = 38'd0;
      step();
      in_carry = 38'd0;
      in_sum   = 38'd5;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp stall %0d in_ready", k), 64'(in_ready), 64'd0);
         check($sformatf("bp stall %0d out_valid", k), 64'(out_valid), 64'd1);
         check($sformatf("bp stall %0d out_sum", k), 64'(out_sum), 64'd3);
         step();
      end
      out_ready = 1'b1;
      #1;
      check("bp release in_ready", 64'(in_ready), 64'd1);
      check("bp release out_sum A", 64'(out_sum), 64'd3);
      step();
      in_valid = 1'b0;
      check("bp out B valid", 64'(out_valid), 64'd1);
      check("bp out B sum", 64'(out_sum), 64'd4);
      step();
      check("bp out C valid", 64'(out_valid), 64'd1);
      check("bp out C sum", 64'(out_sum), 64'd5);
      step();
      check("bp drained", 64'(out_valid), 64'd0);

      // ---- throughput: 100 random pairs back to back ----
      sb_en  = 1'b1;
      stalls = 0;
      for (int i = 0; i < 100; i++) begin
         rnd_c    = {$urandom(), $urandom()};
         rnd_s    = {$urandom(), $urandom()};
         in_carry = rnd_c[WIDTH-1:0];
         in_sum   = rnd_s[WIDTH-1:0];
         in_valid = 1'b1;
         if (!in_ready) stalls++;
         step();
      end
      in_valid = 1'b0;
      for (int k = 0; k < 10 && n_results < 100; k++) step();
      step();
      sb_en = 1'b0;
      check("tp input stalls", 64'(stalls), 64'd0);
      check("tp result count", 64'(n_results), 64'd100);
      check("tp consecutive span", 64'(last_cyc - first_cyc), 64'd99);
      check("tp leftover expected", 64'(exp_q.size()), 64'd0);

      // ---- reset with both stages full ----
      out_ready = 1'b0;
      in_carry  = 38'd7;
      in_sum    = 38'd1;
      in_valid  = 1'b1;
      step();
      in_carry = 38'd3;
      in_sum   = 38'd3;
      step();
      in_valid = 1'b0;
      check("rst full out_valid", 64'(out_valid), 64'd1);
      check("rst full in_ready", 64'(in_ready), 64'd0);
      #2;
      reset = 1'b0;
      #1;
      check("rst async out_valid", 64'(out_valid), 64'd0);
      check("rst async out_sum", 64'(out_sum), 64'd0);
      check("rst async in_ready", 64'(in_ready), 64'd1);
`ifdef CSA_RESOLVE_COUT_EN
      check("rst async out_cout", 64'(out_cout), 64'd0);
`endif
      out_ready = 1'b1;
      step();
      step();
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("rst no stale %0d", k), 64'(out_valid), 64'd0);
      end
      in_carry = 38'h10;
      in_sum   = 38'h1;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      check("rst recover valid", 64'(out_valid), 64'd1);
      check("rst recover sum", 64'(out_sum), 64'h21);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
